// File: rtl/wait_handshake_ctrl.sv
// PC increment/hold control for WAIT: hold the PC until a debounced switch high->low handshake.
// Latency: PCincr drops combinationally on wait_req; release comes 1 cycle after flag_clean falls; ack_pulse follows 1 cycle later.
// Backpressure: none; a WAIT holds the PC indefinitely. Define WAIT_TIMEOUT_EN to add a TIMEOUT_CYCLES expiry.
module wait_handshake_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_req,
    input  logic sw_raw,
    output logic PCincr,
    output logic flag_clean,
    output logic ack_pulse,
    output logic busy,
    output logic timeout
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, WAIT_LO, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
    logic                   flag_q, flag_d;
    logic                   ack_q, ack_d;
    logic                   sync_lvl;
    logic                   in_wait;
    logic                   expire;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign in_wait  = (state_q == ARM) || (state_q == WAIT_LO);

    // The counter measures how long the synchronised level has disagreed with flag_clean.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sw_raw};
        deb_cnt_d = deb_cnt_q;
        flag_d    = flag_q;
        if (sync_lvl == flag_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
            flag_d    = sync_lvl;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

`ifdef WAIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_flag_q, to_flag_d;

    always_comb begin
        expire    = in_wait && (to_cnt_q == TO_LAST);
        to_cnt_d  = '0;
        to_flag_d = to_flag_q | expire;
        if (in_wait && !expire) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign timeout = to_flag_q;
`else
    // Without the timer a WAIT never expires.
    assign expire  = (TIMEOUT_CYCLES < 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        PCincr  = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                PCincr = ~wait_req;
                if (wait_req) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                busy = 1'b1;
                if (expire) begin
                    state_d = RELEASE;
                end else if (flag_q) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                busy = 1'b1;
                if (expire || !flag_q) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                PCincr  = 1'b1;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            deb_cnt_q <= '0;
            flag_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            flag_q    <= flag_d;
            ack_q     <= ack_d;
        end
    end

    assign flag_clean = flag_q;
    assign ack_pulse  = ack_q;

endmodule

// File: tb/tb_wait_handshake_ctrl.sv
// Self-checking bench for wait_handshake_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_wait_handshake_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int TO   = 32;
`ifdef WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic wait_req;
    logic sw_raw;
    logic PCincr, flag_clean, ack_pulse, busy, timeout;

    int n_checks = 0;
    int n_fails  = 0;

    wait_handshake_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wait_req  (wait_req),
        .sw_raw    (sw_raw),
        .PCincr    (PCincr),
        .flag_clean(flag_clean),
        .ack_pulse (ack_pulse),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a WAIT is "in progress" until the clean flag has been
    // seen high and then low (or the wait budget runs out); a release cycle follows.
    bit m_wait, m_seen_hi, m_rel, m_ack, m_flag, m_to, m_expired, m_sync_now;
    int m_run, m_busy_n;
    bit sw_hist [SYNC];

    task automatic m_reset();
        m_wait = 0; m_seen_hi = 0; m_rel = 0; m_ack = 0; m_flag = 0; m_to = 0;
        m_run = 0; m_busy_n = 0;
        for (int i = 0; i < SYNC; i++) sw_hist[i] = 1'b0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reset();
        end else begin
            m_sync_now = sw_hist[SYNC-1];
            m_ack = m_rel;
            if (m_rel) begin
                m_rel = 0;
            end else if (m_wait) begin
                m_busy_n++;
                m_expired = TO_EN && (m_busy_n == TO);
                if (m_expired) m_to = 1;
                if (m_expired || (m_seen_hi && !m_flag)) begin
                    m_wait = 0;
                    m_rel  = 1;
                end else if (m_flag) begin
                    m_seen_hi = 1;
                end
            end else if (wait_req) begin
                m_wait = 1; m_seen_hi = 0; m_busy_n = 0;
            end
            if (m_sync_now != m_flag) begin
                m_run++;
                if (m_run == DEB) begin
                    m_flag = m_sync_now;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            for (int i = SYNC - 1; i > 0; i--) sw_hist[i] = sw_hist[i-1];
            sw_hist[0] = sw_raw;
        end
    end

    always @(negedge clk) begin
        chk("model_PCincr", PCincr, int'(m_rel || (!m_wait && wait_req == 1'b0)));
        chk("model_busy", busy, int'(m_wait));
        chk("model_ack_pulse", ack_pulse, int'(m_ack));
        chk("model_flag_clean", flag_clean, int'(m_flag));
        chk("model_timeout", timeout, int'(m_to));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full switch handshake: 8 cycles high, 8 low, then 8 quiet cycles.
    task automatic handshake(output int rises, output int acks, output int max_run);
        bit last_pc;
        int run;
        rises = 0; acks = 0; max_run = 0; run = 0;
        last_pc = PCincr;
        for (int i = 0; i < 24; i++) begin
            sw_raw = (i < 8);
            @(negedge clk);
            if (PCincr && !last_pc) rises++;
            run = PCincr ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (ack_pulse) acks++;
            last_pc = PCincr;
            tick();
        end
    endtask

    int rises, acks, max_run, cnt_a, cnt_b;

    initial begin
        reset = 1'b0; wait_req = 1'b0; sw_raw = 1'b0;
        // 1: reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_PCincr", PCincr, 1);
        chk("rst_flag_clean", flag_clean, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack_pulse, 0);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_PCincr", PCincr, 1);

        // 2: WAIT entry and single release
        tick();
        wait_req = 1'b1;
        #1;
        chk("hold_same_cycle", PCincr, 0);
        tick();
        @(negedge clk);
        chk("busy_next_cycle", busy, 1);
        tick();
        handshake(rises, acks, max_run);
        chk("t2_release_count", rises, 1);
        chk("t2_ack_count", acks, 1);
        chk("t2_release_width", max_run, 1);

        // 3: short glitch during ARM (wait_req held, so the DUT re-armed)
        sw_raw = 1'b1;
        tick(); tick();
        sw_raw = 1'b0;
        wait_req = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt_a += int'(flag_clean);
            cnt_b += int'(PCincr);
            tick();
        end
        chk("t3_flag_stays_0", cnt_a, 0);
        chk("t3_pc_stays_held", cnt_b, 0);
        @(negedge clk);
        chk("t3_still_armed", busy, 1);
        tick();

        // 4: back-to-back WAITs
        wait_req = 1'b1;
        handshake(rises, acks, max_run);
        chk("t4a_release_count", rises, 1);
        chk("t4a_ack_count", acks, 1);
        chk("t4a_hold_resumes", max_run, 1);
        @(negedge clk);
        chk("t4a_second_wait_busy", busy, 1);
        tick();
        wait_req = 1'b0;
        handshake(rises, acks, max_run);
        chk("t4b_release_count", rises, 1);
        chk("t4b_ack_count", acks, 1);
        @(negedge clk);
        chk("t4b_idle_busy", busy, 0);
        chk("t4b_idle_PCincr", PCincr, 1);
        tick();

        // 5: async reset while in WAIT_LO
        wait_req = 1'b1;
        tick();
        wait_req = 1'b0;
        sw_raw = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        chk("t5_busy_before", busy, 1);
        chk("t5_flag_before", flag_clean, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_PCincr", PCincr, 1);
        chk("t5_async_flag", flag_clean, 0);
        tick();
        sw_raw = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 6: no switch activity
        wait_req = 1'b1;
        tick();
        wait_req = 1'b0;
`ifdef WAIT_TIMEOUT_EN
        cnt_a = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (PCincr) break;
            cnt_a += int'(busy);
            tick();
        end
        chk("t6_released", PCincr, 1);
        chk("t6_busy_cycles", cnt_a, TO);
        chk("t6_timeout_set", timeout, 1);
        repeat (6) tick();
        @(negedge clk);
        chk("t6_timeout_sticky", timeout, 1);
`else
        cnt_a = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cnt_a += int'(PCincr);
            tick();
        end
        chk("t6_no_release", cnt_a, 0);
        @(negedge clk);
        chk("t6_still_busy", busy, 1);
        chk("t6_timeout_zero", timeout, 0);
`endif
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
